// File: rtl/demux_top.sv
// rtl/demux_top.sv - 1-to-4 stream demultiplexer with one holding register and a delivery counter per channel
module demux_top #(
    parameter int DATA_WIDTH = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [1:0]            direction_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data0_o,
    output logic [DATA_WIDTH-1:0] data1_o,
    output logic [DATA_WIDTH-1:0] data2_o,
    output logic [DATA_WIDTH-1:0] data3_o,
    output logic [3:0]            valid_o,
    input  logic [3:0]            ready_i,
    output logic [CNT_WIDTH-1:0]  cnt0_o,
    output logic [CNT_WIDTH-1:0]  cnt1_o,
    output logic [CNT_WIDTH-1:0]  cnt2_o,
    output logic [CNT_WIDTH-1:0]  cnt3_o
);

    logic [DATA_WIDTH-1:0] data_q [4];
    logic [CNT_WIDTH-1:0]  cnt_q  [4];
    logic [3:0]            valid_q;
    logic [3:0]            sel;
    logic [3:0]            drain;
    logic                  load;

    // A full channel still accepts when its sink drains in the same cycle.
    assign ready_o = ~valid_q[direction_i] | ready_i[direction_i];
    assign load    = valid_i & ready_o;
    assign drain   = valid_q & ready_i;

    always_comb begin
        sel = '0;
        if (load) sel[direction_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (sel[k]) begin
                    data_q[k]  <= data_i;
                    valid_q[k] <= 1'b1;
                end else if (drain[k]) begin
                    valid_q[k] <= 1'b0;
                end
                if (drain[k]) cnt_q[k] <= cnt_q[k] + CNT_WIDTH'(1);
            end
        end
    end

    assign valid_o = valid_q;
    assign data0_o = data_q[0];
    assign data1_o = data_q[1];
    assign data2_o = data_q[2];
    assign data3_o = data_q[3];
    assign cnt0_o  = cnt_q[0];
    assign cnt1_o  = cnt_q[1];
    assign cnt2_o  = cnt_q[2];
    assign cnt3_o  = cnt_q[3];

endmodule

// File: tb/tb_demux_top.sv
// tb/tb_demux_top.sv - scoreboard bench for demux_top
module tb_demux_top;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [1:0] data_i;
    logic [1:0] direction_i;
    logic       valid_i;
    logic       ready_o;
    logic [1:0] data0_o, data1_o, data2_o, data3_o;
    logic [3:0] valid_o;
    logic [3:0] ready_i;
    logic [7:0] cnt0_o, cnt1_o, cnt2_o, cnt3_o;

    logic [1:0] dout [4];
    logic [7:0] cout [4];

    logic [1:0] exp_q [4][$];
    logic [7:0] exp_cnt [4];
    logic [3:0] prev_stall;
    logic [1:0] prev_data [4];

    int passed = 0;
    int total  = 0;

    demux_top #(.DATA_WIDTH(2), .CNT_WIDTH(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .direction_i(direction_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .data0_o(data0_o), .data1_o(data1_o), .data2_o(data2_o), .data3_o(data3_o),
        .valid_o(valid_o), .ready_i(ready_i),
        .cnt0_o(cnt0_o), .cnt1_o(cnt1_o), .cnt2_o(cnt2_o), .cnt3_o(cnt3_o)
    );

    assign dout[0] = data0_o;
    assign dout[1] = data1_o;
    assign dout[2] = data2_o;
    assign dout[3] = data3_o;
    assign cout[0] = cnt0_o;
    assign cout[1] = cnt1_o;
    assign cout[2] = cnt2_o;
    assign cout[3] = cnt3_o;

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        else
            passed++;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            exp_cnt[k] = '0;
            prev_data[k] = '0;
        end
        prev_stall = '0;
    endtask

    // Called at posedge+1; returns whether the word was taken at the next edge.
    task automatic drive(input logic v, input logic [1:0] dir, input logic [1:0] d,
                         input logic [3:0] rdy, output logic acc);
        valid_i = v; direction_i = dir; data_i = d; ready_i = rdy;
        @(negedge clk_i);
        acc = v & ready_o;
        if (acc) exp_q[dir].push_back(d);
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: sampled on the falling edge, transfers complete on the next rising edge.
    initial begin
        clear_model();
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("cnt%0d", k), 32'(cout[k]), 32'(exp_cnt[k]));
                    if (prev_stall[k] && valid_o[k])
                        check($sformatf("stall_stable%0d", k), 32'(dout[k]), 32'(prev_data[k]));
                    if (valid_o[k] && ready_i[k]) begin
                        if (exp_q[k].size() == 0) begin
                            total++;
                            $display("FAIL deliver%0d: got %0h expected no word at %0t", k, dout[k], $time);
                        end else begin
                            check($sformatf("deliver%0d", k), 32'(dout[k]), 32'(exp_q[k].pop_front()));
                        end
                        exp_cnt[k] = exp_cnt[k] + 8'd1;
                    end
                    prev_stall[k] = valid_o[k] & ~ready_i[k];
                    prev_data[k]  = dout[k];
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic acc;
        int tries;
        rst_ni = 1'b0; valid_i = 1'b0; direction_i = 2'd0; data_i = 2'd0; ready_i = 4'b0000;
        #1;
        check("rst_valid", 32'(valid_o), 32'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_data%0d", k), 32'(dout[k]), 32'h0);
            check($sformatf("rst_cnt%0d", k), 32'(cout[k]), 32'h0);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        for (int d = 0; d < 4; d++) begin
            direction_i = 2'(d);
            #0.5;
            check($sformatf("empty_ready_dir%0d", d), 32'(ready_o), 32'h1);
        end
        @(posedge clk_i); #1;

        // Single load into channel 2
        drive(1'b1, 2'd2, 2'b11, 4'b0000, acc);
        check("load2_acc", 32'(acc), 32'h1);
        check("load2_valid", 32'(valid_o), 32'h4);
        check("load2_data", 32'(data2_o), 32'h3);

        // Stalled channel 2 blocks only its own inputs
        valid_i = 1'b1; direction_i = 2'd2; data_i = 2'b00; ready_i = 4'b0000;
        #1;
        check("stall2_ready", 32'(ready_o), 32'h0);
        drive(1'b1, 2'd2, 2'b00, 4'b0000, acc);
        check("stall2_acc", 32'(acc), 32'h0);
        check("stall2_data", 32'(data2_o), 32'h3);
        check("stall2_valid", 32'(valid_o), 32'h4);
        drive(1'b1, 2'd1, 2'b01, 4'b0000, acc);
        check("ch1_acc", 32'(acc), 32'h1);
        check("ch1_valid", 32'(valid_o), 32'h6);
        check("ch1_data", 32'(data1_o), 32'h1);
        drive(1'b0, 2'd0, 2'd0, 4'b1111, acc);
        check("drain_valid", 32'(valid_o), 32'h0);
        check("drain_data2_kept", 32'(data2_o), 32'h3);

        // Full throughput stream into channel 3
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'd3, 2'(i), 4'b1111, acc);
            check("stream3_acc", 32'(acc), 32'h1);
        end
        drive(1'b0, 2'd0, 2'd0, 4'b1111, acc);
        check("stream3_cnt", 32'(cnt3_o), 32'd16);

        // Asynchronous reset between edges
        drive(1'b1, 2'd0, 2'b10, 4'b0000, acc);
        drive(1'b1, 2'd3, 2'b01, 4'b0000, acc);
        check("fill03_valid", 32'(valid_o), 32'h9);
        valid_i = 1'b0;
        #1;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", 32'(valid_o), 32'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("arst_cnt%0d", k), 32'(cout[k]), 32'h0);
            check($sformatf("arst_data%0d", k), 32'(dout[k]), 32'h0);
        end
        clear_model();
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Counter wrap on channel 0
        for (int i = 0; i < 257; i++) drive(1'b1, 2'd0, 2'(i), 4'b0001, acc);
        drive(1'b0, 2'd0, 2'd0, 4'b0001, acc);
        check("wrap_cnt0", 32'(cnt0_o), 32'd1);

        // All {direction,data} combinations with random sink backpressure
        for (int i = 0; i < 1024; i++) begin
            tries = 0;
            acc = 1'b0;
            while (!acc && tries < 100) begin
                drive(1'b1, 2'(i >> 2), 2'(i), 4'($urandom_range(0, 15)), acc);
                tries++;
            end
            if (!acc) begin
                total++;
                $display("FAIL accept_timeout: word %0d not taken after %0d cycles", i, tries);
            end
        end
        drive(1'b0, 2'd0, 2'd0, 4'b1111, acc);
        drive(1'b0, 2'd0, 2'd0, 4'b1111, acc);
        check("final_valid", 32'(valid_o), 32'h0);
        for (int k = 0; k < 4; k++)
            check($sformatf("final_queue%0d", k), 32'(exp_q[k].size()), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/demux_top.md
DEMUX_TOP -- requirements
Module: demux_top

Interface
REQ-001 Parameter DATA_WIDTH, default 2, width of every data word.
REQ-002 Parameter CNT_WIDTH, default 8, width of each per-channel delivery counter.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 data_i  input  DATA_WIDTH  input word.
REQ-006 direction_i  input  2  destination channel of data_i (0..3), sampled with valid_i.
REQ-007 valid_i  input  1  data_i/direction_i valid.
REQ-008 ready_o  output  1  block accepts the input word this cycle.
REQ-009 data0_o..data3_o  output  DATA_WIDTH each  per-channel output word.
REQ-010 valid_o  output  4  bit k = channel k holds a word.
REQ-011 ready_i  input  4  bit k = channel k sink accepts its word.
REQ-012 cnt0_o..cnt3_o  output  CNT_WIDTH each  words delivered per channel.

Function
REQ-013 Input transfer occurs on a rising edge with valid_i=1 and ready_o=1; output transfer on channel k occurs with valid_o[k]=1 and ready_i[k]=1.
REQ-014 Each channel has one holding register (data + valid flag); no other storage.
REQ-015 ready_o SHALL be combinational: ready_o = ~valid_o[direction_i] | ready_i[direction_i]; no dependence on valid_i.
REQ-016 On an input transfer, dataK_o (K = direction_i) loads data_i and valid_o[K] sets at the next edge; latency exactly 1 cycle.
REQ-017 Channels not addressed by direction_i SHALL hold data and valid unchanged except when drained.
REQ-018 On an output transfer on channel k with no simultaneous load into k, valid_o[k] clears next edge; dataK_o retains its last value.
REQ-019 Simultaneous drain and load on the same channel: valid_o[k] stays 1, dataK_o takes the new word; full throughput of one word/cycle to a single channel.
REQ-020 A stalled channel (valid_o[k]=1, ready_i[k]=0) blocks only inputs addressed to k; other channels keep draining and loading.
REQ-021 While valid_o[k]=1 and ready_i[k]=0, dataK_o SHALL remain stable.
REQ-022 valid_i=1 with ready_o=0: no state change; the source holds data_i/direction_i until accepted.
REQ-023 cntK_o increments by 1 on each output transfer on channel K; wraps from 2^CNT_WIDTH-1 to 0.
REQ-024 All four channels may complete output transfers in the same cycle; each counter updates independently.
REQ-025 Outputs SHALL have no combinational path from data_i, valid_i or direction_i other than ready_o.

Reset
REQ-026 rst_ni=0 SHALL immediately, without a clock edge, force valid_o=4'b0000, data0_o..data3_o=0, cnt0_o..cnt3_o=0.
REQ-027 Reset asserted mid-operation discards all held words; no output transfer is counted in a cycle in which rst_ni=0.
REQ-028 After rst_ni deasserts, the first edge may accept input; ready_o=1 for any direction_i while all channels are empty.

Verification
REQ-029 Reset, then valid_i=1, direction_i=2, data_i=2'b11, ready_i=4'b0000 for one cycle -> next cycle valid_o=4'b0100, data2_o=2'b11, other channels unchanged.
REQ-030 With channel 2 full and ready_i[2]=0, present direction_i=2 -> ready_o=0 and data2_o stable; switch to direction_i=1, data_i=2'b01 -> ready_o=1, next cycle valid_o=4'b0110.
REQ-031 ready_i=4'b1111, stream 16 words all to channel 3 on consecutive cycles -> ready_o=1 every cycle, data3_o follows input with 1-cycle latency, cnt3_o=16.
REQ-032 Loop all 1024 combinations of {direction_i, data_i} (DATA_WIDTH=2, repeated) with random ready_i -> every delivered word matches a scoreboard per channel in order, no loss or duplication, counters equal scoreboard counts.
REQ-033 Fill channels 0 and 3, pulse rst_ni low between clock edges -> valid_o=4'b0000 and all counters 0 before the next edge.
REQ-034 Drive 257 deliveries on channel 0 (CNT_WIDTH=8) -> cnt0_o=1 after wrap.
